// File: rtl/mips32_memarb_pkg.sv
// Shared types and the address screening helper for the mips32 memory arbiter.
// Optional feature macro used by the arbiter: MEMARB_PERF_EN.
package mips32_memarb_pkg;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_F    = 2'd1,
        PORT_D    = 2'd2
    } port_e;

    typedef struct packed {
        logic  valid;
        logic  err;
        port_e port;
    } resp_t;

    // A byte address is bad if it is not word aligned or points past the last RAM word.
    function automatic logic addr_bad(input logic [63:0] addr, input logic [63:0] mem_words);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= mem_words);
    endfunction

endpackage

// File: rtl/mips32_memarb_resp_pipe.sv
// Holds the tag of the operation granted this cycle and, one cycle later,
// steers the RAM read data to the fetch or data response port.
module mips32_memarb_resp_pipe
    import mips32_memarb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  resp_t            tag,
    input  logic             tag_store,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             f_rvalid,
    output logic             f_err,
    output logic [WIDTH-1:0] f_rdata,
    output logic             d_rvalid,
    output logic             d_err,
    output logic [WIDTH-1:0] d_rdata
);

    resp_t tag_q;
    logic  store_q;
    logic  live;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_q   <= '0;
            store_q <= 1'b0;
        end else begin
            tag_q   <= tag;
            store_q <= tag_store;
        end
    end

    // Gating with reset drops an in-flight response the moment reset is asserted.
    assign live     = reset & tag_q.valid;

    assign f_rvalid = live & (tag_q.port == PORT_F);
    assign f_err    = f_rvalid & tag_q.err;
    assign f_rdata  = (f_rvalid & ~tag_q.err) ? mem_rdata : '0;

    assign d_rvalid = live & (tag_q.port == PORT_D);
    assign d_err    = d_rvalid & tag_q.err;
    assign d_rdata  = (d_rvalid & ~tag_q.err & ~store_q) ? mem_rdata : '0;

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port sync-read RAM, data first
// with a fetch starvation limit. Optional counters under MEMARB_PERF_EN.
module mips32_mem_arbiter
    import mips32_memarb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MEM_WORDS  = 256,
    parameter int STARVE_MAX = 4,
    parameter int AW         = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_req,
    input  logic [WIDTH-1:0] f_addr,
    output logic             f_gnt,
    output logic             f_rvalid,
    output logic [WIDTH-1:0] f_rdata,
    output logic             f_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_err,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
`ifdef MEMARB_PERF_EN
    output logic [31:0]      conflict_cycles,
    output logic [31:0]      fetch_stall_cycles,
    output logic [31:0]      forced_fetch,
`endif
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;
    logic          starve_full;
    logic          f_bad;
    logic          d_bad;
    resp_t         tag;
    logic          tag_store;

    assign starve_full = (starve_cnt == SW'(STARVE_MAX));
    assign f_bad       = addr_bad(64'(f_addr), 64'(MEM_WORDS));
    assign d_bad       = addr_bad(64'(d_addr), 64'(MEM_WORDS));

    // Handshake: a requester holds req and its payload until it sees gnt in the same
    // cycle; the response appears exactly one cycle later and is never back-pressured.
    assign d_gnt = reset & d_req & ~(f_req & starve_full);
    assign f_gnt = reset & f_req & ~d_gnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (f_gnt || !f_req) begin
            starve_cnt <= '0;
        end else if (d_gnt && !starve_full) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Screened requests keep their grant slot but never strobe the RAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tag       = '0;
        tag_store = 1'b0;
        if (d_gnt) begin
            mem_en    = ~d_bad;
            mem_we    = d_we & ~d_bad;
            mem_addr  = d_addr[AW+1:2];
            mem_wdata = d_wdata;
            tag       = '{valid: 1'b1, err: d_bad, port: PORT_D};
            tag_store = d_we;
        end else if (f_gnt) begin
            mem_en    = ~f_bad;
            mem_addr  = f_addr[AW+1:2];
            tag       = '{valid: 1'b1, err: f_bad, port: PORT_F};
        end
    end

    mips32_memarb_resp_pipe #(
        .WIDTH(WIDTH)
    ) u_resp_pipe (
        .clk       (clk),
        .reset     (reset),
        .tag       (tag),
        .tag_store (tag_store),
        .mem_rdata (mem_rdata),
        .f_rvalid  (f_rvalid),
        .f_err     (f_err),
        .f_rdata   (f_rdata),
        .d_rvalid  (d_rvalid),
        .d_err     (d_err),
        .d_rdata   (d_rdata)
    );

`ifdef MEMARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cycles    <= '0;
            fetch_stall_cycles <= '0;
            forced_fetch       <= '0;
        end else begin
            if (f_req && d_req)
                conflict_cycles <= conflict_cycles + 32'd1;
            if (f_req && !f_gnt)
                fetch_stall_cycles <= fetch_stall_cycles + 32'd1;
            if (f_req && d_req && starve_full)
                forced_fetch <= forced_fetch + 32'd1;
        end
    end
`endif

endmodule
